scan_chain_rx: RTL and testbench
================================

Name: scan_chain_rx

Overview:
- Receive-side counterpart of the tag-chip scan/hop controller.
- Samples the scan-chain GPIO lines (scan_id, phi, phi_bar, data_in, load_chip) and the hop-synch line from the front-panel GPIO input register.
- Deserialises each scan word and reports it with its bit count and protocol errors.
- Counts hop-synch pulses. Used on a second radio or as loopback checker to verify the chip-programming stream.

Parameters:
GPIO_REG_WIDTH, 12, width of fp_gpio_in
TX_BITS_WIDTH, 128, width of shift register and rx_bits
BIT_CNT_WIDTH, 7, width of bit counter
NTX_BITS, 78, expected bits per load; mismatch flags len_err
HOP_CNT_WIDTH, 8, width of hop counter
ID_BIT, 10, GPIO index of scan_id
PHI_BIT, 8, GPIO index of scan_phi
PHI_BAR_BIT, 6, GPIO index of scan_phi_bar
DATA_BIT, 4, GPIO index of scan_data_in
LOAD_BIT, 2, GPIO index of scan_load_chip
SYNC_BIT, 0, GPIO index of hop synch

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
fp_gpio_in  in  GPIO_REG_WIDTH  raw (asynchronous) front-panel inputs
rx_bits  out  TX_BITS_WIDTH  last latched scan word
rx_nbits  out  BIT_CNT_WIDTH  bits shifted before last load
rx_valid  out  1  one-cycle pulse when rx_bits/rx_nbits update
len_err  out  1  last load had rx_nbits != NTX_BITS; updated with rx_valid
ovf_err  out  1  last load saw more than 2^BIT_CNT_WIDTH-1 bits; updated with rx_valid
phase_err  out  1  sticky: phi and phi_bar simultaneously high
hop_cnt  out  HOP_CNT_WIDTH  hop-synch rising edges seen, wraps
busy  out  1  high while in SHIFT state

Behaviour:
- Input conditioning:
  - Each of the 6 used GPIO bits passes through a 2-FF synchroniser, then a 1-FF delay for edge detection.
  - A rise means sync2=1 and dly=0. All logic below uses synchronised signals only.
- Reset:
  - rx_bits=0, rx_nbits=0, rx_valid=0, len_err=0, ovf_err=0, phase_err=0, hop_cnt=0, busy=0.
  - Shift register=0, bit count=0, state=IDLE. Synchroniser FFs are cleared.
  - Reset mid-word discards all partial data; no rx_valid is produced for that word.
- FSM:
  - IDLE: busy=0. scan_id high -> SHIFT, clearing shift register and bit count.
  - SHIFT: busy=1. On phi rise:
    - shift register <= {sr[TX_BITS_WIDTH-2:0], data}, with data sampled as the synchronised value in the same cycle.
    - Bit count increments, saturating at all-ones. A phi rise at saturation sets an internal ovf flag.
  - SHIFT, load rise -> LOADED:
    - rx_bits <= shift register. The first-shifted bit sits at index rx_nbits-1; the last-shifted bit sits at index 0.
    - rx_nbits <= count; len_err <= (count != NTX_BITS); ovf_err <= ovf flag.
    - rx_valid=1 for exactly one cycle.
  - SHIFT, scan_id falls without a load: return to IDLE silently.
  - LOADED: wait for load to fall, then -> SHIFT if scan_id is high, else IDLE. Clear count and ovf flag on exit.
  - Load rise in IDLE or LOADED: ignored.
- Latency: rx_valid is high in the 4th cycle after the first clk edge that samples fp_gpio_in[LOAD_BIT]=1 (2 sync + 1 edge + 1 register).
- Simultaneous phi rise and load rise in the same cycle: the bit is shifted and counted first. The latched word and count include it.
- phase_err: set on any cycle where sync phi=1 and sync phi_bar=1. It stays set until reset and does not block reception.
- Hop synch:
  - Each rise of SYNC_BIT increments hop_cnt, wrapping from all-ones to 0.
  - It also forces state=IDLE and clears shift register and count.
  - If a load rise occurs in the same cycle, the load is processed first (rx_valid fires), then the clear applies.
- phi_bar carries no data. It is used only for the overlap check.

Test Plan:
- Shift 78 bits of pattern 0xA5 repeating, then load -> rx_valid pulses once, rx_nbits=78, len_err=0, ovf_err=0, rx_bits[77:0] equals the pattern, first bit at index 77.
- 10-bit word 0x2B5 then load -> rx_nbits=10, rx_bits=0x2B5, len_err=1.
- 130 phi pulses then load -> rx_nbits=127, ovf_err=1, rx_bits holds the last 128 bits shifted.
- phi and phi_bar overlap for 1 synced cycle during a 78-bit word -> phase_err=1 and stays high; word still received correctly.
- Hop synch pulse mid-word, then 78-bit word and load -> hop_cnt=1; rx_nbits=78, counting only post-synch bits. After 256 synch pulses, hop_cnt wraps to 0.
- Assert reset after 40 bits, release, then load with no new bits -> no rx_valid. All outputs hold reset values.

Source files
------------

// File: rtl/scan_chain_rx.sv
// Receive side of the tag-chip scan/hop link: synchronises the scan GPIO lines,
// deserialises each scan word on phi rises and latches it on a load rise.
module scan_chain_rx #(
    parameter int GPIO_REG_WIDTH = 12,
    parameter int TX_BITS_WIDTH  = 128,
    parameter int BIT_CNT_WIDTH  = 7,
    parameter int NTX_BITS       = 78,
    parameter int HOP_CNT_WIDTH  = 8,
    parameter int ID_BIT         = 10,
    parameter int PHI_BIT        = 8,
    parameter int PHI_BAR_BIT    = 6,
    parameter int DATA_BIT       = 4,
    parameter int LOAD_BIT       = 2,
    parameter int SYNC_BIT       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [TX_BITS_WIDTH-1:0]  rx_bits,
    output logic [BIT_CNT_WIDTH-1:0]  rx_nbits,
    output logic                      rx_valid,
    output logic                      len_err,
    output logic                      ovf_err,
    output logic                      phase_err,
    output logic [HOP_CNT_WIDTH-1:0]  hop_cnt,
    output logic                      busy
);
    localparam int NSIG   = 6;
    localparam int S_ID   = 0;
    localparam int S_PHI  = 1;
    localparam int S_PHIB = 2;
    localparam int S_DATA = 3;
    localparam int S_LOAD = 4;
    localparam int S_SYNC = 5;
    localparam int GPIO_IDX [NSIG] = '{ID_BIT, PHI_BIT, PHI_BAR_BIT, DATA_BIT, LOAD_BIT, SYNC_BIT};

    typedef enum logic [1:0] {IDLE, SHIFT, LOADED} state_t;

    logic [NSIG-1:0] raw;
    logic [NSIG-1:0] sync1_reg, sync2_reg, dly_reg, lvl_reg, rise_reg;
    logic            unused_gpio;

    generate
        for (genvar gi = 0; gi < NSIG; gi++) begin : g_pick
            assign raw[gi] = fp_gpio_in[GPIO_IDX[gi]];
        end
    endgenerate
    assign unused_gpio = ^fp_gpio_in;

    // lvl_reg is aligned with rise_reg so levels and edges seen by the FSM come from the same sample
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            dly_reg   <= '0;
            lvl_reg   <= '0;
            rise_reg  <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            dly_reg   <= sync2_reg;
            lvl_reg   <= sync2_reg;
            rise_reg  <= sync2_reg & ~dly_reg;
        end
    end

    state_t                     state_reg, state_next;
    logic [TX_BITS_WIDTH-1:0]   sr_reg, sr_next;
    logic [BIT_CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                       ovf_reg, ovf_next;
    logic [TX_BITS_WIDTH-1:0]   rx_bits_reg, rx_bits_next;
    logic [BIT_CNT_WIDTH-1:0]   rx_nbits_reg, rx_nbits_next;
    logic                       rx_valid_reg, rx_valid_next;
    logic                       len_err_reg, len_err_next;
    logic                       ovf_err_reg, ovf_err_next;
    logic                       phase_err_reg;
    logic [HOP_CNT_WIDTH-1:0]   hop_cnt_reg, hop_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            sr_reg        <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            rx_bits_reg   <= '0;
            rx_nbits_reg  <= '0;
            rx_valid_reg  <= 1'b0;
            len_err_reg   <= 1'b0;
            ovf_err_reg   <= 1'b0;
            phase_err_reg <= 1'b0;
            hop_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            cnt_reg       <= cnt_next;
            ovf_reg       <= ovf_next;
            rx_bits_reg   <= rx_bits_next;
            rx_nbits_reg  <= rx_nbits_next;
            rx_valid_reg  <= rx_valid_next;
            len_err_reg   <= len_err_next;
            ovf_err_reg   <= ovf_err_next;
            hop_cnt_reg   <= hop_cnt_next;
            if (sync2_reg[S_PHI] && sync2_reg[S_PHIB])
                phase_err_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sr_next       = sr_reg;
        cnt_next      = cnt_reg;
        ovf_next      = ovf_reg;
        rx_bits_next  = rx_bits_reg;
        rx_nbits_next = rx_nbits_reg;
        rx_valid_next = 1'b0;
        len_err_next  = len_err_reg;
        ovf_err_next  = ovf_err_reg;
        hop_cnt_next  = hop_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (lvl_reg[S_ID]) begin
                    state_next = SHIFT;
                    sr_next    = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            SHIFT: begin
                // A phi rise coincident with the load rise is folded into the latched word
                if (rise_reg[S_PHI]) begin
                    sr_next = {sr_reg[TX_BITS_WIDTH-2:0], lvl_reg[S_DATA]};
                    if (&cnt_reg)
                        ovf_next = 1'b1;
                    else
                        cnt_next = cnt_reg + 1'b1;
                end
                if (rise_reg[S_LOAD]) begin
                    rx_bits_next  = sr_next;
                    rx_nbits_next = cnt_next;
                    len_err_next  = (cnt_next != BIT_CNT_WIDTH'(NTX_BITS));
                    ovf_err_next  = ovf_next;
                    rx_valid_next = 1'b1;
                    state_next    = LOADED;
                end else if (!lvl_reg[S_ID]) begin
                    state_next = IDLE;
                end
            end
            LOADED: begin
                if (!lvl_reg[S_LOAD]) begin
                    state_next = lvl_reg[S_ID] ? SHIFT : IDLE;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Hop synch overrides the FSM after any same-cycle load has been latched above
        if (rise_reg[S_SYNC]) begin
            hop_cnt_next = hop_cnt_reg + 1'b1;
            state_next   = IDLE;
            sr_next      = '0;
            cnt_next     = '0;
            ovf_next     = 1'b0;
        end
    end

    assign rx_bits   = rx_bits_reg;
    assign rx_nbits  = rx_nbits_reg;
    assign rx_valid  = rx_valid_reg;
    assign len_err   = len_err_reg;
    assign ovf_err   = ovf_err_reg;
    assign phase_err = phase_err_reg;
    assign hop_cnt   = hop_cnt_reg;
    assign busy      = (state_reg == SHIFT);

endmodule

// File: tb/tb_scan_chain_rx.sv
// Directed bench for scan_chain_rx: drives the GPIO scan protocol and checks each
// latched word against a queue of expected results filled as bits are driven.
module tb_scan_chain_rx;
    localparam int ID = 10, PHI = 8, PHIB = 6, DATA = 4, LOAD = 2, SYNC = 0;

    logic         clk = 1'b0;
    logic         reset;
    logic [11:0]  gpio;
    logic [127:0] rx_bits;
    logic [6:0]   rx_nbits;
    logic         rx_valid, len_err, ovf_err, phase_err, busy;
    logic [7:0]   hop_cnt;

    scan_chain_rx dut (
        .clk(clk), .reset(reset), .fp_gpio_in(gpio),
        .rx_bits(rx_bits), .rx_nbits(rx_nbits), .rx_valid(rx_valid),
        .len_err(len_err), .ovf_err(ovf_err), .phase_err(phase_err),
        .hop_cnt(hop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] bits;
        int           nbits;
        bit           len;
        bit           ovf;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc_cnt = 0;
    logic [127:0] m_sr;
    int           m_cnt;
    bit           m_ovf;
    bit           prev_valid = 1'b0;

    always @(posedge clk) cyc_cnt++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each rx_valid pops one expected word and checks contents and latency
    always @(negedge clk) begin
        if (!reset && rx_valid) begin
            check("valid_one_cycle", 128'(prev_valid), 128'(0));
            if (q.size() == 0) begin
                check("spurious_valid", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("word: nbits=%0d len=%0b ovf=%0b bits=%0h", rx_nbits, len_err, ovf_err, rx_bits);
                check("rx_bits", rx_bits, e.bits);
                check("rx_nbits", 128'(rx_nbits), 128'(e.nbits));
                check("len_err", 128'(len_err), 128'(e.len));
                check("ovf_err", 128'(ovf_err), 128'(e.ovf));
                check("latency", 128'(cyc_cnt), 128'(e.cyc));
            end
        end
        prev_valid = rx_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_word();
        m_sr = '0; m_cnt = 0; m_ovf = 1'b0;
        gpio[ID] = 1'b1;
        cyc(5);
    endtask

    task automatic end_word();
        gpio[ID] = 1'b0;
        cyc(5);
    endtask

    task automatic model_shift(input bit b);
        m_sr = {m_sr[126:0], b};
        if (m_cnt == 127) m_ovf = 1'b1;
        else m_cnt++;
    endtask

    task automatic push_exp();
        exp_t e;
        e.bits = m_sr; e.nbits = m_cnt; e.len = (m_cnt != 78); e.ovf = m_ovf;
        e.cyc = cyc_cnt + 4;
        q.push_back(e);
    endtask

    task automatic shift_bit(input bit b, input bit overlap);
        gpio[DATA] = b;
        cyc(2);
        gpio[PHI] = 1'b1;
        model_shift(b);
        cyc(1);
        if (overlap) begin
            gpio[PHIB] = 1'b1;
            cyc(1);
            gpio[PHIB] = 1'b0;
            cyc(1);
        end else cyc(2);
        gpio[PHI] = 1'b0;
        cyc(3);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            cyc(1);
            n++;
        end
        if (q.size() > 0) begin
            check("valid_timeout", 128'(q.size()), 128'(0));
            q.delete();
        end
    endtask

    task automatic do_load();
        push_exp();
        gpio[LOAD] = 1'b1;
        cyc(5);
        gpio[LOAD] = 1'b0;
        cyc(4);
        wait_drain();
    endtask

    task automatic hop_pulse();
        gpio[SYNC] = 1'b1;
        cyc(4);
        gpio[SYNC] = 1'b0;
        cyc(4);
    endtask

    initial begin
        logic [7:0]   pat;
        logic [127:0] exp_bits;
        logic [9:0]   w10;
        bit           b;

        gpio  = '0;
        reset = 1'b1;
        cyc(4);
        reset = 1'b0;
        cyc(2);
        check("reset_rx_bits", rx_bits, 128'(0));
        check("reset_nbits", 128'(rx_nbits), 128'(0));
        check("reset_flags", 128'({rx_valid, len_err, ovf_err, phase_err, busy}), 128'(0));
        check("reset_hop", 128'(hop_cnt), 128'(0));

        // 78 bits of 0xA5 repeating, MSB of each byte first
        pat = 8'hA5;
        exp_bits = '0;
        start_word();
        check("busy_shift", 128'(busy), 128'(1));
        for (int i = 0; i < 78; i++) begin
            b = pat[7 - (i % 8)];
            exp_bits[77 - i] = b;
            shift_bit(b, 1'b0);
        end
        do_load();
        check("a5_pattern", rx_bits, exp_bits);
        check("a5_len_ok", 128'({len_err, ovf_err}), 128'(0));
        end_word();
        check("idle_not_busy", 128'(busy), 128'(0));

        // 10-bit word
        w10 = 10'h2B5;
        start_word();
        for (int i = 9; i >= 0; i--) shift_bit(w10[i], 1'b0);
        do_load();
        check("w10_bits", rx_bits, 128'h2B5);
        check("w10_len_err", 128'(len_err), 128'(1));
        end_word();

        // Last bit's phi rise coincides with the load rise
        start_word();
        for (int i = 0; i < 3; i++) shift_bit(1'b1, 1'b0);
        gpio[DATA] = 1'b0;
        cyc(2);
        model_shift(1'b0);
        push_exp();
        gpio[PHI] = 1'b1;
        gpio[LOAD] = 1'b1;
        cyc(3);
        gpio[PHI] = 1'b0;
        cyc(2);
        gpio[LOAD] = 1'b0;
        cyc(4);
        wait_drain();
        check("simul_bits", rx_bits, 128'hE);
        end_word();

        // 130 bits: count saturates and overflow is flagged
        start_word();
        for (int i = 0; i < 130; i++) shift_bit(1'($urandom_range(0, 1)), 1'b0);
        do_load();
        check("ovf_nbits", 128'(rx_nbits), 128'(127));
        check("ovf_flag", 128'(ovf_err), 128'(1));
        end_word();

        // phi/phi_bar overlap for one cycle during a 78-bit word
        check("phase_pre", 128'(phase_err), 128'(0));
        start_word();
        for (int i = 0; i < 78; i++) shift_bit(1'($urandom_range(0, 1)), i == 20);
        do_load();
        check("phase_set", 128'(phase_err), 128'(1));
        end_word();
        check("phase_sticky", 128'(phase_err), 128'(1));

        // Hop synch mid-word discards the partial word
        start_word();
        for (int i = 0; i < 5; i++) shift_bit(1'b1, 1'b0);
        hop_pulse();
        m_sr = '0; m_cnt = 0; m_ovf = 1'b0;
        for (int i = 0; i < 78; i++) shift_bit(1'($urandom_range(0, 1)), 1'b0);
        do_load();
        check("hop_one", 128'(hop_cnt), 128'(1));
        end_word();
        for (int i = 0; i < 254; i++) hop_pulse();
        check("hop_255", 128'(hop_cnt), 128'(255));
        hop_pulse();
        check("hop_wrap", 128'(hop_cnt), 128'(0));

        // Reset mid-word, then a load with no new bits
        start_word();
        for (int i = 0; i < 40; i++) shift_bit(1'b1, 1'b0);
        check("busy_pre_reset", 128'(busy), 128'(1));
        reset = 1'b1;
        gpio[ID] = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(6);
        gpio[LOAD] = 1'b1;
        cyc(5);
        gpio[LOAD] = 1'b0;
        cyc(10);
        check("rst_rx_bits", rx_bits, 128'(0));
        check("rst_nbits", 128'(rx_nbits), 128'(0));
        check("rst_flags", 128'({rx_valid, len_err, ovf_err, phase_err, busy}), 128'(0));
        check("rst_hop", 128'(hop_cnt), 128'(0));
        check("queue_empty", 128'(q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
